hc_request_scheduler: RTL and testbench

- Shares the single HardCloud requestor command path between HC_BUFFER_SIZE per-buffer requesters (TX buffers first, then RX).
- Each requester presents a t_request_control.
- The scheduler does four things:
  - gates traffic on the HC_CONTROL start/stop decode;
  - arbitrates round-robin between requesters;
  - bounds-checks each offset against the CSR-programmed buffer size;
  - limits in-flight commands with a credit counter.
- Sits between the buffer engines and the read/write requestor FSMs.

---
 rtl/hc_pkg.sv | 44 ++++
 rtl/hc_rr_arbiter.sv | 45 ++++
 rtl/hc_request_scheduler.sv | 168 ++++++++++++++++
 tb/tb_hc_request_scheduler.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hc_pkg.sv
// Shared HardCloud types and constants used by the request scheduler and the requestor FSMs.
package hc_pkg;

  localparam int unsigned HC_BUFFER_SIZE   = 2;  // TX buffers first, then RX
  localparam int unsigned HC_REQUEST_DEPTH = 8;
  localparam int unsigned HC_ID_WIDTH      = 8;
  localparam int unsigned HC_OFFSET_WIDTH  = 32;

  localparam int unsigned HC_SCHED_MAX_OUTSTANDING = HC_REQUEST_DEPTH;

  typedef enum logic [1:0] {
    e_REQUEST_IDLE  = 2'd0,
    e_REQUEST_READ  = 2'd1,
    e_REQUEST_WRITE = 2'd2
  } t_request_cmd;

  typedef logic [HC_ID_WIDTH-1:0] t_request_cmd_id;

  typedef struct packed {
    t_request_cmd                 cmd;
    t_request_cmd_id              id;
    logic [HC_OFFSET_WIDTH-1:0]   offset;
  } t_request_control;

  // size is counted in cache lines
  typedef struct packed {
    logic [63:0] address;
    logic [31:0] size;
  } t_hc_buffer;

  typedef enum logic [1:0] {
    S_SCHED_IDLE,
    S_SCHED_RUN,
    S_SCHED_DRAIN
  } t_sched_state;

  typedef logic [$clog2(HC_SCHED_MAX_OUTSTANDING + 1)-1:0] t_sched_credit;

  // Only read and write are commands the requestors can execute.
  function automatic logic hc_cmd_legal(t_request_cmd cmd);
    return (cmd == e_REQUEST_READ) || (cmd == e_REQUEST_WRITE);
  endfunction

endpackage

// File: rtl/hc_rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant plus binary index; the pointer moves past the
// winner only when the caller signals that the grant was taken (advance).
module hc_rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic [IW-1:0] rr_ptr;
  logic [IW:0]   cand;
  logic          found;

  // Pick the first requester at or after rr_ptr, wrapping around
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req[cand[IW-1:0]]) begin
        found                 = 1'b1;
        grant[cand[IW-1:0]]   = 1'b1;
        index                 = cand[IW-1:0];
      end
    end
  end

  // Rotate priority to just past the granted requester
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (index == IW'(N - 1)) ? '0 : index + IW'(1);
    end
  end

endmodule

// File: rtl/hc_request_scheduler.sv
// Shares the HardCloud requestor command path between per-buffer requesters: start/stop
// gating, round-robin arbitration, offset bounds checking and an in-flight credit limit.
// Optional grant/stall performance counters are built when HC_SCHED_PERF_EN is defined.
module hc_request_scheduler
  import hc_pkg::*;
#(
  parameter int unsigned N_REQ           = HC_BUFFER_SIZE,
  parameter int unsigned MAX_OUTSTANDING = HC_SCHED_MAX_OUTSTANDING
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  t_hc_buffer [N_REQ-1:0]       buffer_cfg,
  input  logic [N_REQ-1:0]             req_valid,
  input  t_request_control [N_REQ-1:0] req_ctrl,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         out_valid,
  output t_request_control             out_ctrl,
  input  logic                         out_ready,
  input  logic                         cpl_valid,
  output logic                         busy,
  output logic                         done,
  output logic                         err_oob,
  output t_request_cmd_id              err_id,
  output logic [N_REQ-1:0][31:0]       perf_grants,
  output logic [31:0]                  perf_stall
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  t_sched_state      state_q, state_d;
  logic              done_q, done_d;
  logic [CW-1:0]     outstanding_q;
  logic [N_REQ-1:0]  arb_grant;
  logic [IW-1:0]     arb_index;
  logic              start_accept, slot_free, credit_ok, granted, legal, fwd, drop;
  logic              credit_inc, credit_dec;
  t_request_control  sel_ctrl, fwd_ctrl;
  logic              unused_cfg_bits;

  // Buffer addresses and incoming ids are not needed for scheduling.
  assign unused_cfg_bits = ^{buffer_cfg, req_ctrl};

  assign start_accept = (state_q == S_SCHED_IDLE) && start;
  assign slot_free    = !out_valid || out_ready;
  // A command held in the output register has already claimed its credit.
  assign credit_ok    = ({1'b0, outstanding_q} + (CW+1)'(out_valid)) < (CW+1)'(MAX_OUTSTANDING);
  assign granted      = (state_q == S_SCHED_RUN) && slot_free && credit_ok && (|req_valid);
  assign req_ready    = granted ? arb_grant : '0;

  assign sel_ctrl = req_ctrl[arb_index];
  assign legal    = hc_cmd_legal(sel_ctrl.cmd) && (sel_ctrl.offset < buffer_cfg[arb_index].size);
  assign fwd      = granted && legal;
  assign drop     = granted && !legal;

  assign credit_inc = out_valid && out_ready;
  assign credit_dec = cpl_valid && (outstanding_q != '0);

  assign busy = (state_q != S_SCHED_IDLE);
  assign done = done_q;

  hc_rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (granted),
    .grant   (arb_grant),
    .index   (arb_index)
  );

  // Forwarded command carries the requester index as its id
  always_comb begin
    fwd_ctrl    = sel_ctrl;
    fwd_ctrl.id = t_request_cmd_id'(arb_index);
  end

  // Next state and drain-complete pulse
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_SCHED_IDLE:  if (start) state_d = S_SCHED_RUN;
      S_SCHED_RUN:   if (stop) state_d = S_SCHED_DRAIN;
      S_SCHED_DRAIN: begin
        if ((outstanding_q == '0) && !out_valid) begin
          state_d = S_SCHED_IDLE;
          done_d  = 1'b1;
        end
      end
      default:       state_d = S_SCHED_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_SCHED_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Output slot: load on forward, hold until the requestor takes it
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (fwd) begin
      out_valid <= 1'b1;
      out_ctrl  <= fwd_ctrl;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // In-flight credit counter; a completion with nothing in flight is ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_q <= '0;
    end else if (credit_inc && !credit_dec) begin
      outstanding_q <= outstanding_q + CW'(1);
    end else if (!credit_inc && credit_dec) begin
      outstanding_q <= outstanding_q - CW'(1);
    end
  end

  // Sticky drop error, remembering the first offender
  always_ff @(posedge clk) begin
    if (reset || start_accept) begin
      err_oob <= 1'b0;
      err_id  <= '0;
    end else if (drop) begin
      err_oob <= 1'b1;
      if (!err_oob) err_id <= t_request_cmd_id'(arb_index);
    end
  end

`ifdef HC_SCHED_PERF_EN
  logic [N_REQ-1:0][31:0] perf_grants_q;
  logic [31:0]            perf_stall_q;

  // Per-requester forwarded count and stalled run cycles, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (reset || start_accept) begin
      perf_grants_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (fwd) perf_grants_q[arb_index] <= perf_grants_q[arb_index] + 32'd1;
      if ((state_q == S_SCHED_RUN) && (|req_valid) && !granted) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_grants = perf_grants_q;
  assign perf_stall  = perf_stall_q;
`else
  assign perf_grants = '0;
  assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_hc_request_scheduler.sv
// Self-checking bench for hc_request_scheduler: cycle-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_hc_request_scheduler;
  import hc_pkg::*;

  localparam int N    = HC_BUFFER_SIZE;
  localparam int MAXO = HC_SCHED_MAX_OUTSTANDING;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset, start, stop, out_ready, cpl_valid;
  t_hc_buffer [N-1:0]       buffer_cfg;
  logic [N-1:0]             req_valid, req_ready;
  t_request_control [N-1:0] req_ctrl;
  logic                     out_valid, busy, done, err_oob;
  t_request_control         out_ctrl;
  t_request_cmd_id          err_id;
  logic [N-1:0][31:0]       perf_grants;
  logic [31:0]              perf_stall;

  hc_request_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .buffer_cfg  (buffer_cfg),
    .req_valid   (req_valid),
    .req_ctrl    (req_ctrl),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_ctrl    (out_ctrl),
    .out_ready   (out_ready),
    .cpl_valid   (cpl_valid),
    .busy        (busy),
    .done        (done),
    .err_oob     (err_oob),
    .err_id      (err_id),
    .perf_grants (perf_grants),
    .perf_stall  (perf_stall)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: 0 idle, 1 run, 2 drain; m_out counts commands handed to the requestor
  int               m_state, m_ptr, m_out, m_eid, m_ps;
  bit               m_ov, m_done, m_err;
  t_request_control m_oc;
  int               m_pg [N];

  // Observation log for the directed literal checks
  int ready_cnt, ov_cnt, done_cnt, done_cyc, first_rdy_cyc, first_ov_cyc;
  int grant_log[$];
  int id_log[$];
  bit auto_bump = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    ready_cnt = 0; ov_cnt = 0; done_cnt = 0; done_cyc = -1;
    first_rdy_cyc = -1; first_ov_cyc = -1;
    grant_log.delete(); id_log.delete();
  endtask

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_out = 0; m_eid = 0; m_ps = 0;
    m_ov = 0; m_done = 0; m_err = 0; m_oc = '0;
    for (int i = 0; i < N; i++) m_pg[i] = 0;
  endtask

  // Which requester the rules allow to win this cycle, or -1
  function automatic int model_grant();
    if (m_state != 1) return -1;
    if (m_ov && !out_ready) return -1;
    if (m_out + int'(m_ov) >= MAXO) return -1;
    for (int k = 0; k < N; k++) begin
      if (((req_valid >> ((m_ptr + k) % N)) & 1) != 0) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic bit model_legal(int g);
    t_request_control c = req_ctrl[g];
    return (c.cmd == e_REQUEST_READ || c.cmd == e_REQUEST_WRITE) &&
           (c.offset < buffer_cfg[g].size);
  endfunction

  task automatic compare();
    int g;
    logic [N-1:0] exp_rdy;
    g = model_grant();
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov) chk("out_ctrl", 64'(out_ctrl), 64'(m_oc));
    chk("busy", 64'(busy), 64'(m_state != 0));
    chk("done", 64'(done), 64'(m_done));
    chk("err_oob", 64'(err_oob), 64'(m_err));
    chk("err_id", 64'(err_id), 64'(m_eid));
    for (int i = 0; i < N; i++) begin
`ifdef HC_SCHED_PERF_EN
      chk("perf_grants", 64'(perf_grants[i]), 64'(32'(m_pg[i])));
`else
      chk("perf_grants", 64'(perf_grants[i]), 64'(0));
`endif
    end
`ifdef HC_SCHED_PERF_EN
    chk("perf_stall", 64'(perf_stall), 64'(32'(m_ps)));
`else
    chk("perf_stall", 64'(perf_stall), 64'(0));
`endif
    if (req_ready != '0) begin
      ready_cnt++;
      if (first_rdy_cyc < 0) first_rdy_cyc = cyc;
      for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);
    end
    if (out_valid) begin
      ov_cnt++;
      if (first_ov_cyc < 0) first_ov_cyc = cyc;
      if (out_ready) id_log.push_back(int'(out_ctrl.id));
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic model_update();
    int g, old_out, nstate;
    bit legal;
    if (reset) begin
      model_reset();
      return;
    end
    g = model_grant();
    legal = (g >= 0) && model_legal(g);
    old_out = m_out;
    nstate = m_state;
    m_done = 0;
    if (m_state == 0 && start) begin
      nstate = 1; m_err = 0; m_eid = 0; m_ps = 0;
      for (int i = 0; i < N; i++) m_pg[i] = 0;
    end else if (m_state == 1 && stop) begin
      nstate = 2;
    end else if (m_state == 2 && m_out == 0 && !m_ov) begin
      nstate = 0; m_done = 1;
    end
    if (m_state == 1 && req_valid != '0 && g < 0) m_ps++;
    if (g >= 0 && legal) m_pg[g]++;
    if (g >= 0 && !legal) begin
      if (!m_err) m_eid = g;
      m_err = 1;
    end
    m_out = old_out + ((m_ov && out_ready) ? 1 : 0) - ((cpl_valid && old_out > 0) ? 1 : 0);
    if (g >= 0 && legal) begin
      m_ov = 1;
      m_oc = req_ctrl[g];
      m_oc.id = t_request_cmd_id'(g);
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (g >= 0) m_ptr = (g + 1) % N;
    m_state = nstate;
  endtask

  // One clock: inputs already driven at the falling edge
  task automatic step();
    logic [N-1:0] acc;
    #1;
    compare();
    acc = req_ready;
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
    if (auto_bump) begin
      for (int i = 0; i < N; i++)
        if (acc[i]) req_ctrl[i].offset = (req_ctrl[i].offset + 32'd1) & 32'd3;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1; start = 1'b0; stop = 1'b0; cpl_valid = 1'b0; req_valid = '0;
    step();
    reset = 1'b0;
    for (int i = 0; i < N; i++) req_ctrl[i] = '{cmd: e_REQUEST_READ, id: '0, offset: '0};
    clear_logs();
  endtask

  task automatic rand_ctrl(input int i);
    int r;
    r = $urandom_range(0, 9);
    req_ctrl[i].cmd = (r == 0) ? e_REQUEST_IDLE : (r == 1) ? t_request_cmd'(2'd3) :
                      (r < 6) ? e_REQUEST_READ : e_REQUEST_WRITE;
    req_ctrl[i].id = t_request_cmd_id'($urandom);
    req_ctrl[i].offset = $urandom_range(0, int'(buffer_cfg[i].size) + 1);
  endtask

  initial begin
    t_request_control snap;
    int c_last;
    reset = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b0; cpl_valid = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      buffer_cfg[i] = '{address: 64'(32'h1000 * (i + 1)), size: 32'd16};
      req_ctrl[i] = '{cmd: e_REQUEST_READ, id: '0, offset: '0};
    end
    model_reset();
    clear_logs();
    @(posedge clk);
    @(negedge clk);
    step();
    reset = 1'b0;
    chk("reset_out_ctrl", 64'(out_ctrl), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));

    // No start: requests must be ignored
    req_valid = 2'b11;
    run(10);
    chk("nostart_ready", 64'(ready_cnt), 64'(0));
    chk("nostart_out_valid", 64'(ov_cnt), 64'(0));

    // Round-robin with free-flowing output
    reset_dut();
    out_ready = 1'b1;
    pulse_start();
    auto_bump = 1'b1;
    req_valid = 2'b11;
    run(6);
    auto_bump = 1'b0;
    chk("rr_grants_n", 64'(grant_log.size()), 64'(6));
    for (int i = 0; i < 4; i++) begin
      chk("rr_grant_order", 64'(grant_log[i]), 64'(i % 2));
      chk("rr_out_id", 64'(id_log[i]), 64'(i % 2));
    end
    chk("rr_latency", 64'(first_ov_cyc - first_rdy_cyc), 64'(1));

    // Credit limit, single refill and simultaneous handshake + completion
    reset_dut();
    out_ready = 1'b1;
    pulse_start();
    req_valid = 2'b11;
    run(14);
    chk("credit_limit", 64'(ready_cnt), 64'(MAXO));
    cpl_valid = 1'b1; step(); cpl_valid = 1'b0;
    run(5);
    chk("credit_one_more", 64'(ready_cnt), 64'(MAXO + 1));
    cpl_valid = 1'b1; step(); cpl_valid = 1'b0; step();
    cpl_valid = 1'b1; step(); cpl_valid = 1'b0;
    run(6);
    chk("credit_simultaneous", 64'(ready_cnt), 64'(MAXO + 3));

    // Out-of-bounds drop and sticky first error id
    reset_dut();
    buffer_cfg[1].size = 32'd4;
    out_ready = 1'b1;
    pulse_start();
    req_ctrl[1].offset = 32'd4;
    req_valid = 2'b10; step(); req_valid = 2'b00; step();
    chk("oob_acked", 64'(ready_cnt), 64'(1));
    chk("oob_not_forwarded", 64'(ov_cnt), 64'(0));
    chk("oob_err", 64'(err_oob), 64'(1));
    chk("oob_err_id", 64'(err_id), 64'(1));
    req_ctrl[1].offset = 32'd3;
    req_valid = 2'b10; step(); req_valid = 2'b00; step();
    chk("oob_in_range_fwd", 64'(ov_cnt), 64'(1));
    req_ctrl[0].offset = 32'd20;
    req_valid = 2'b01; step(); req_valid = 2'b00; step();
    chk("oob_err_id_sticky", 64'(err_id), 64'(1));
    buffer_cfg[1].size = 32'd16;

    // Drain with 3 in flight and one held in the output slot
    reset_dut();
    out_ready = 1'b1;
    pulse_start();
    req_valid = 2'b11;
    run(4);
    out_ready = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;
    run(5);
    chk("drain_no_grants", 64'(ready_cnt), 64'(4));
    req_valid = 2'b00;
    out_ready = 1'b1; step(); out_ready = 1'b0;
    c_last = 0;
    for (int i = 0; i < 4; i++) begin
      c_last = cyc;
      cpl_valid = 1'b1; step(); cpl_valid = 1'b0; step();
    end
    run(3);
    chk("drain_done_once", 64'(done_cnt), 64'(1));
    chk("drain_done_timing", 64'(done_cyc - c_last), 64'(2));
    chk("drain_idle", 64'(busy), 64'(0));

    // Backpressure hold, then reset with commands in flight
    reset_dut();
    out_ready = 1'b1;
    pulse_start();
    req_valid = 2'b11;
    run(6);
    out_ready = 1'b0;
    snap = out_ctrl;
    c_last = ready_cnt;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_ctrl_stable", 64'(out_ctrl), 64'(snap));
    end
    chk("bp_no_ready", 64'(ready_cnt), 64'(c_last));
    reset = 1'b1; step(); reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_ctrl", 64'(out_ctrl), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    cpl_valid = 1'b1; run(2); cpl_valid = 1'b0;
    out_ready = 1'b1;
    clear_logs();
    pulse_start();
    run(12);
    chk("rst_credits_cleared", 64'(ready_cnt), 64'(MAXO));

    // Randomized traffic
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0)
        for (int i = 0; i < N; i++) buffer_cfg[i].size = $urandom_range(1, 12);
      reset     = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 29) == 0);
      stop      = ($urandom_range(0, 39) == 0);
      req_valid = N'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      cpl_valid = ($urandom_range(0, 9) < 3);
      for (int i = 0; i < N; i++) rand_ctrl(i);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
